// File: rtl/stage_if_prefetch_pkg.sv
// Shared types for the RV32I fetch stage: bus widths, fetch FSM encodings and default reset PC.
package stage_if_prefetch_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int INST_W     = 32;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [INST_W-1:0]     inst_t;

  localparam mem_addr_t DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_WAIT  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_t;

endpackage

// File: rtl/stage_if_prefetch_fifo.sv
// Synchronous prefetch FIFO with flush; the head entry is exposed combinationally.
module stage_if_prefetch_fifo
  import stage_if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    head_reg, tail_reg;
  logic [PW:0]      count_reg, count_next;
  logic [DEPTH-1:0] wr_en;
  logic             do_push, do_pop;

  // Flush wins over push and pop so a redirect never leaves a stale entry behind.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (tail_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_reg[i] <= push_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign head_data = mem_reg[head_reg];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PW+1)'(DEPTH));

endmodule

// File: rtl/stage_if_prefetch.sv
// RV32I instruction fetch stage: owns the fetch PC and keeps a small queue of prefetched words.
module stage_if_prefetch
  import stage_if_prefetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = MEM_ADDR_W,
  parameter int                    INST_WIDTH = INST_W,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  br,
  input  logic [ADDR_WIDTH-1:0] br_addr,
  input  logic                  ram_busy,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic                  ram_ready,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic [INST_WIDTH-1:0] ram_data_i,
  output logic                  stall_if,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [INST_WIDTH-1:0] inst_o
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH;

  if_state_t             state_reg;
  logic [ADDR_WIDTH-1:0] fetch_pc_reg, req_addr_reg;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, resp_match;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    head_entry;

  assign ram_read   = !reset && (state_reg == IF_IDLE) && (fifo_count < CNT_W'(DEPTH)) && !br;
  assign ram_addr_o = ram_read ? fetch_pc_reg : '0;
  assign resp_match = ram_ready && (ram_addr_i == req_addr_reg);
  assign fifo_push  = (state_reg == IF_WAIT) && resp_match && !br;

  assign stall_if = fifo_empty || br;
  assign fifo_pop = !stall_if && !stall_in;
  assign pc_o     = stall_if ? '0 : head_entry[ENTRY_W-1:INST_WIDTH];
  assign inst_o   = stall_if ? '0 : head_entry[INST_WIDTH-1:0];

  stage_if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({req_addr_reg, ram_data_i}),
    .pop       (fifo_pop),
    .flush     (br),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IF_IDLE;
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= '0;
    end else if (br) begin
      fetch_pc_reg <= br_addr;
      // A response landing in the redirect cycle is the stale one, so nothing is left to drain.
      case (state_reg)
        IF_WAIT, IF_DRAIN: state_reg <= ram_ready ? IF_IDLE : IF_DRAIN;
        default:           state_reg <= IF_IDLE;
      endcase
    end else begin
      case (state_reg)
        IF_IDLE: begin
          if (ram_read && !ram_busy) begin
            req_addr_reg <= fetch_pc_reg;
            state_reg    <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (resp_match) begin
            fetch_pc_reg <= fetch_pc_reg + ADDR_WIDTH'(PC_STEP);
            state_reg    <= IF_IDLE;
          end
        end
        IF_DRAIN: begin
          if (ram_ready) state_reg <= IF_IDLE;
        end
        default: state_reg <= IF_IDLE;
      endcase
    end
  end

  // Issue is gated on free space and only one request is ever in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fifo_push && fifo_full));
    end
  end

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed-vector bench for stage_if_prefetch plus a free-running memory-model sequence.
module tb_stage_if_prefetch;

  logic        clk = 1'b0;
  logic        reset, stall_in, br, ram_busy, ram_ready;
  logic [31:0] br_addr, ram_addr_i, ram_data_i;
  logic        ram_read, stall_if;
  logic [31:0] ram_addr_o, pc_o, inst_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage_if_prefetch dut (
    .clk        (clk),
    .reset      (reset),
    .stall_in   (stall_in),
    .br         (br),
    .br_addr    (br_addr),
    .ram_busy   (ram_busy),
    .ram_read   (ram_read),
    .ram_addr_o (ram_addr_o),
    .ram_ready  (ram_ready),
    .ram_addr_i (ram_addr_i),
    .ram_data_i (ram_data_i),
    .stall_if   (stall_if),
    .pc_o       (pc_o),
    .inst_o     (inst_o)
  );

  typedef struct {
    logic        rst, stl, br;
    logic [31:0] bra;
    logic        busy, rdy;
    logic [31:0] rai;
    logic        chk;
    logic        erd;
    logic [31:0] era;
    logic        esif;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input int chk_en, input int rst, input int stl, input int brv,
                      input logic [31:0] bra, input int busy, input int rdy,
                      input logic [31:0] rai, input int erd, input logic [31:0] era,
                      input int esif, input logic [31:0] epc);
    vec_t t;
    t.rst  = (rst != 0);
    t.stl  = (stl != 0);
    t.br   = (brv != 0);
    t.bra  = bra;
    t.busy = (busy != 0);
    t.rdy  = (rdy != 0);
    t.rai  = rai;
    t.chk  = (chk_en != 0);
    t.erd  = (erd != 0);
    t.era  = era;
    t.esif = (esif != 0);
    t.epc  = epc;
    vecs.push_back(t);
  endtask

  // v(rst, stall_in, br, br_addr, busy, ready, resp_addr, exp_read, exp_addr, exp_stall_if, exp_pc)
  task automatic v(input int rst, input int stl, input int brv, input logic [31:0] bra,
                   input int busy, input int rdy, input logic [31:0] rai, input int erd,
                   input logic [31:0] era, input int esif, input logic [31:0] epc);
    addv(1, rst, stl, brv, bra, busy, rdy, rai, erd, era, esif, epc);
  endtask

  // First reset cycle starts from an unknown state, the second one is checked.
  task automatic rp();
    addv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic fill_two_then_wait8();
    v(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    v(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    v(0, 1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 1, 8, 0, 0);
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; br = 1'b0; br_addr = '0;
    ram_busy = 1'b0; ram_ready = 1'b0; ram_addr_i = '0; ram_data_i = '0;

    // Basic sequential fetch with a one-cycle memory.
    rp();
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    v(0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 4);
    v(0, 0, 0, 0, 0, 1, 8, 0, 0, 1, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 'hC, 0, 8);

    // Downstream stall fills the queue, then it drains back-to-back.
    rp();
    v(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    v(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    v(0, 1, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 1, 8, 0, 0);
    v(0, 1, 0, 0, 0, 1, 8, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 1, 'hC, 0, 0);
    v(0, 1, 0, 0, 0, 1, 'hC, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 'h10, 0, 4);
    v(0, 0, 0, 0, 1, 0, 0, 1, 'h10, 0, 8);
    v(0, 0, 0, 0, 1, 0, 0, 1, 'h10, 0, 'hC);
    v(0, 0, 0, 0, 0, 0, 0, 1, 'h10, 1, 0);
    v(0, 0, 0, 0, 0, 1, 'h10, 0, 0, 1, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 'h14, 0, 'h10);

    // Redirect while waiting on 0x8; stale response arrives three cycles later.
    rp();
    fill_two_then_wait8();
    v(0, 1, 1, 'h100, 0, 0, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 1, 8, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 'h100, 1, 0);
    v(0, 0, 0, 0, 0, 1, 'h100, 0, 0, 1, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 'h104, 0, 'h100);

    // Redirect coincides with the response for 0x4; also a mismatched response in WAIT.
    rp();
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    v(0, 0, 1, 'h200, 0, 1, 4, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 'h200, 1, 0);
    v(0, 0, 0, 0, 0, 1, 'h999, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 1, 'h200, 0, 0, 1, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 'h204, 0, 'h200);

    // Memory busy for five cycles holds the request steady.
    rp();
    for (int k = 0; k < 5; k++) v(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 4, 0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 4, 1, 0);

    // Reset in WAIT with two words queued.
    rp();
    fill_two_then_wait8();
    v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0);

    // Redirect from IDLE to the top of the address space, then PC wraps to 0.
    rp();
    v(0, 0, 1, 'hFFFF_FFFC, 0, 0, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 'hFFFF_FFFC, 1, 0);
    v(0, 0, 0, 0, 0, 1, 'hFFFF_FFFC, 0, 0, 1, 0);
    v(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 'hFFFF_FFFC);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset      = vecs[i].rst;
      stall_in   = vecs[i].stl;
      br         = vecs[i].br;
      br_addr    = vecs[i].bra;
      ram_busy   = vecs[i].busy;
      ram_ready  = vecs[i].rdy;
      ram_addr_i = vecs[i].rai;
      ram_data_i = dat(vecs[i].rai);
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("v%0d.ram_read", i), 32'(ram_read), 32'(vecs[i].erd));
        chk($sformatf("v%0d.ram_addr_o", i), ram_addr_o, vecs[i].era);
        chk($sformatf("v%0d.stall_if", i), 32'(stall_if), 32'(vecs[i].esif));
        chk($sformatf("v%0d.pc_o", i), pc_o, vecs[i].epc);
        chk($sformatf("v%0d.inst_o", i), inst_o, vecs[i].esif ? 32'h0 : dat(vecs[i].epc));
      end
      $display("vec %0d: rst=%0d br=%0d rd=%0d ra=%h sif=%0d pc=%h inst=%h",
               i, reset, br, ram_read, ram_addr_o, stall_if, pc_o, inst_o);
    end

    // Free-running sequence: memory answers one cycle after accept, random stalls and busy.
    begin
      logic        pend;
      logic [31:0] pend_addr, next_req, exp_pc;
      int          delivered;
      pend = 1'b0; pend_addr = '0; next_req = '0; exp_pc = '0; delivered = 0;
      @(negedge clk);
      reset = 1'b1; stall_in = 1'b0; br = 1'b0; ram_busy = 1'b0; ram_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 80; c++) begin
        if (c != 0) @(negedge clk);
        stall_in   = ($urandom_range(0, 2) == 0);
        ram_busy   = ($urandom_range(0, 3) == 0);
        ram_ready  = pend;
        ram_addr_i = pend_addr;
        ram_data_i = dat(pend_addr);
        #1;
        pend = 1'b0;
        if (ram_read) begin
          chk("seq.req_addr", ram_addr_o, next_req);
          if (!ram_busy) begin
            pend      = 1'b1;
            pend_addr = ram_addr_o;
            next_req  = next_req + 32'd4;
          end
        end
        if (!stall_if && !stall_in) begin
          chk("seq.pc_o", pc_o, exp_pc);
          chk("seq.inst_o", inst_o, dat(exp_pc));
          $display("seq cycle %0d: consumed pc=%h inst=%h", c, pc_o, inst_o);
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
      chk("seq.delivered_at_least_8", 32'(delivered >= 8), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
